// File: rtl/osc_seq_pkg.sv
// Shared types and constants for the DDS oscillator control sequencer.
package osc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_PRIME  = 3'd3,
    S_RUN    = 3'd4,
    S_CHANGE = 3'd5
  } state_t;

  localparam int MODE_MAX   = 4;
  // Mode whose zero-cross detector uses the 9-bit window
  localparam int MODE_FINE  = 4;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 6;
  localparam int DEF_DIV_W  = 16;

  function automatic logic mode_is_fine(input logic [2:0] mode);
    return mode == 3'(MODE_FINE);
  endfunction

endpackage

// File: rtl/osc_tick_div.sv
// Loadable modulo counter: tick pulses in the cycle the count equals the divisor.
module osc_tick_div
  import osc_seq_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             Fg_clk,
  input  logic             Resetn,
  input  logic             clear,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             run,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  assign tick = run && (cnt_q == div_q);

  // A load restarts the count so a new divisor never sees a stale phase
  always_ff @(posedge Fg_clk) begin
    if (!Resetn) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div;
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/osc_sequencer.sv
// Command/prime/tick sequencer in front of the DDS sine oscillator.
// Optional sample counter enabled by defining OSC_SEQ_TICKCNT_EN.
module osc_sequencer
  import osc_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic                     Fg_clk,
  input  logic                     Resetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_mode,
  input  logic [IDX_W-1:0]         cmd_freq_idx,
  input  logic [DIV_W-1:0]         cmd_div,
  output logic [IDX_W-1:0]         tbl_addr,
  input  logic signed [DATA_W-1:0] tbl_sin,
  input  logic signed [DATA_W-1:0] tbl_cos,
  output logic                     osc_ready,
  output logic                     osc_enable,
  output logic                     osc_freqchng,
  output logic [2:0]               osc_mode,
  output logic signed [DATA_W-1:0] osc_init1,
  output logic signed [DATA_W-1:0] osc_init2,
  output logic                     running,
  output logic [31:0]              sample_cnt
);

  state_t           state_q, state_d;
  logic             from_run_q;
  logic             cfg_loaded_q;
  logic [2:0]       mode_sh_q;
  logic [DIV_W-1:0] div_sh_q;

  logic accept, latch_en, abort, dv_clear, in_run, tick;

  assign cmd_ready = Resetn && !stop && ((state_q == S_IDLE) || (state_q == S_RUN));

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    latch_en = 1'b0;
    abort    = 1'b0;
    dv_clear = 1'b0;
    in_run   = (state_q == S_RUN) ||
               (from_run_q && ((state_q == S_FETCH) || (state_q == S_LATCH) ||
                               (state_q == S_CHANGE)));
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      abort   = (state_q == S_FETCH) || (state_q == S_LATCH);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            accept  = 1'b1;
            state_d = S_FETCH;
          end else if (start && cfg_loaded_q) begin
            state_d = S_PRIME;
          end
        end
        S_FETCH: state_d = S_LATCH;
        S_LATCH: begin
          latch_en = 1'b1;
          if (!from_run_q)                state_d = S_IDLE;
          else if (mode_sh_q == osc_mode) state_d = S_CHANGE;
          else                            state_d = S_PRIME;
        end
        S_PRIME: begin
          dv_clear = 1'b1;
          state_d  = S_RUN;
        end
        S_RUN: begin
          if (cmd_valid && cmd_ready) begin
            accept  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_CHANGE: state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Fg_clk) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Command capture and coefficient latch; a stop before the latch leaves no usable config
  always_ff @(posedge Fg_clk) begin
    if (!Resetn) begin
      tbl_addr     <= '0;
      mode_sh_q    <= '0;
      div_sh_q     <= '0;
      from_run_q   <= 1'b0;
      cfg_loaded_q <= 1'b0;
      osc_mode     <= '0;
      osc_init1    <= '0;
      osc_init2    <= '0;
    end else begin
      if (accept) begin
        tbl_addr   <= cmd_freq_idx;
        mode_sh_q  <= cmd_mode;
        div_sh_q   <= cmd_div;
        from_run_q <= (state_q == S_RUN);
      end
      if (latch_en) begin
        osc_init1    <= tbl_sin;
        osc_init2    <= tbl_cos;
        osc_mode     <= mode_sh_q;
        cfg_loaded_q <= 1'b1;
      end
      if (abort) cfg_loaded_q <= 1'b0;
    end
  end

  osc_tick_div #(.DIV_W(DIV_W)) u_div (
    .Fg_clk (Fg_clk),
    .Resetn (Resetn),
    .clear  (dv_clear),
    .load   (latch_en),
    .div    (div_sh_q),
    .run    (in_run),
    .tick   (tick)
  );

  // Pulses are suppressed in the stop cycle so the oscillator never sees a half-aborted request
  assign osc_ready    = Resetn && !stop && (state_q == S_PRIME);
  assign osc_freqchng = Resetn && !stop && (state_q == S_CHANGE);
  assign osc_enable   = Resetn && !stop && tick;
  assign running      = Resetn && in_run;

`ifdef OSC_SEQ_TICKCNT_EN
  logic [31:0] sample_cnt_q;
  always_ff @(posedge Fg_clk) begin
    if (!Resetn)         sample_cnt_q <= '0;
    else if (dv_clear)   sample_cnt_q <= '0;
    else if (osc_enable) sample_cnt_q <= sample_cnt_q + 32'd1;
  end
  assign sample_cnt = sample_cnt_q;
`else
  assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_osc_sequencer.sv
// Directed, table-driven bench for osc_sequencer with a synchronous ROM model.
module tb_osc_sequencer;

  localparam logic [31:0] I5A = 32'h0100_0000;
  localparam logic [31:0] I5B = 32'h3FF0_0000;
  localparam logic [31:0] I9A = 32'h0080_0000;
  localparam logic [31:0] I9B = 32'h3FFC_0000;

  logic        Fg_clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_mode = '0;
  logic [5:0]  cmd_freq_idx = '0;
  logic [15:0] cmd_div = '0;
  logic [5:0]  tbl_addr;
  logic [31:0] tbl_sin = '0, tbl_cos = '0;
  logic        osc_ready, osc_enable, osc_freqchng, running;
  logic [2:0]  osc_mode;
  logic [31:0] osc_init1, osc_init2, sample_cnt;

  int checks = 0;
  int failures = 0;

  osc_sequencer dut (
    .Fg_clk(Fg_clk), .Resetn(Resetn), .start(start), .stop(stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_freq_idx(cmd_freq_idx), .cmd_div(cmd_div), .tbl_addr(tbl_addr),
    .tbl_sin(tbl_sin), .tbl_cos(tbl_cos), .osc_ready(osc_ready),
    .osc_enable(osc_enable), .osc_freqchng(osc_freqchng), .osc_mode(osc_mode),
    .osc_init1(osc_init1), .osc_init2(osc_init2), .running(running),
    .sample_cnt(sample_cnt)
  );

  always #5 Fg_clk = ~Fg_clk;

  function automatic logic [31:0] rom_sin(input logic [5:0] a);
    case (a)
      6'd5:    return I5A;
      6'd9:    return I9A;
      default: return 32'(a) << 12;
    endcase
  endfunction

  function automatic logic [31:0] rom_cos(input logic [5:0] a);
    case (a)
      6'd5:    return I5B;
      6'd9:    return I9B;
      default: return 32'h4000_0000;
    endcase
  endfunction

  always @(posedge Fg_clk) begin
    tbl_sin <= rom_sin(tbl_addr);
    tbl_cos <= rom_cos(tbl_addr);
  end

  typedef struct {
    logic        start, stop, cv;
    logic [2:0]  mode;
    logic [5:0]  idx;
    logic [15:0] div;
    logic [4:0]  flags;   // cmd_ready, osc_ready, osc_enable, osc_freqchng, running
    logic [2:0]  e_mode;
    logic [31:0] e_i1, e_i2;
  } vec_t;

  function automatic vec_t v(input logic st, input logic sp, input logic cv,
                             input logic [2:0] m, input logic [5:0] ix, input logic [15:0] dv,
                             input logic [4:0] fl, input logic [2:0] em, input int isel);
    vec_t r;
    r.start = st; r.stop = sp; r.cv = cv; r.mode = m; r.idx = ix; r.div = dv;
    r.flags = fl; r.e_mode = em;
    r.e_i1 = (isel == 1) ? I5A : (isel == 2) ? I9A : 32'h0;
    r.e_i2 = (isel == 1) ? I5B : (isel == 2) ? I9B : 32'h0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Fg_clk);
    #1;
  endtask

  vec_t tbl[29];
  logic [31:0] exp_cnt10;

  initial begin
    // Main scenario: load, prime, tick, freq change, mode change, stop+cmd
    tbl[0]  = v(0,0,1, 3'd0,6'd5,16'd3, 5'b10000, 3'd0, 0);
    tbl[1]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00000, 3'd0, 0);
    tbl[2]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00000, 3'd0, 0);
    tbl[3]  = v(1,0,0, 3'd0,6'd0,16'd0, 5'b10000, 3'd0, 1);
    tbl[4]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b01000, 3'd0, 1);
    tbl[5]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 1);
    tbl[6]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 1);
    tbl[7]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 1);
    tbl[8]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10101, 3'd0, 1);
    tbl[9]  = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 1);
    tbl[10] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 1);
    tbl[11] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 1);
    tbl[12] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10101, 3'd0, 1);
    tbl[13] = v(0,0,1, 3'd0,6'd9,16'd3, 5'b10001, 3'd0, 1);
    tbl[14] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00001, 3'd0, 1);
    tbl[15] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00001, 3'd0, 1);
    tbl[16] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00011, 3'd0, 2);
    tbl[17] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 2);
    tbl[18] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd0, 2);
    tbl[19] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10101, 3'd0, 2);
    tbl[20] = v(0,0,1, 3'd4,6'd9,16'd2, 5'b10001, 3'd0, 2);
    tbl[21] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00001, 3'd0, 2);
    tbl[22] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b00001, 3'd0, 2);
    tbl[23] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b01000, 3'd4, 2);
    tbl[24] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd4, 2);
    tbl[25] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10001, 3'd4, 2);
    tbl[26] = v(0,1,1, 3'd0,6'd1,16'd0, 5'b00001, 3'd4, 2);
    tbl[27] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10000, 3'd4, 2);
    tbl[28] = v(0,0,0, 3'd0,6'd0,16'd0, 5'b10000, 3'd4, 2);

`ifdef OSC_SEQ_TICKCNT_EN
    exp_cnt10 = 32'd10;
`else
    exp_cnt10 = 32'd0;
`endif

    // Reset state
    step();
    step();
    @(negedge Fg_clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_sample_cnt", sample_cnt, 32'd0);
    chk("rst_tbl_addr", {26'd0, tbl_addr}, 32'd0);
    step();
    Resetn = 1'b1;

    for (int i = 0; i < 29; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; cmd_valid = tbl[i].cv;
      cmd_mode = tbl[i].mode; cmd_freq_idx = tbl[i].idx; cmd_div = tbl[i].div;
      @(negedge Fg_clk);
      chk($sformatf("v%0d_cmd_ready", i), {31'd0, cmd_ready}, {31'd0, tbl[i].flags[4]});
      chk($sformatf("v%0d_osc_ready", i), {31'd0, osc_ready}, {31'd0, tbl[i].flags[3]});
      chk($sformatf("v%0d_osc_enable", i), {31'd0, osc_enable}, {31'd0, tbl[i].flags[2]});
      chk($sformatf("v%0d_freqchng", i), {31'd0, osc_freqchng}, {31'd0, tbl[i].flags[1]});
      chk($sformatf("v%0d_running", i), {31'd0, running}, {31'd0, tbl[i].flags[0]});
      chk($sformatf("v%0d_mode", i), {29'd0, osc_mode}, {29'd0, tbl[i].e_mode});
      chk($sformatf("v%0d_init1", i), osc_init1, tbl[i].e_i1);
      chk($sformatf("v%0d_init2", i), osc_init2, tbl[i].e_i2);
      step();
    end
    start = 1'b0; stop = 1'b0; cmd_valid = 1'b0;
    @(negedge Fg_clk);
    chk("stopcmd_not_taken_addr", {26'd0, tbl_addr}, 32'd9);
    step();

    // div=0: tick every cycle, sample counter, restart clears counter
    cmd_valid = 1'b1; cmd_mode = 3'd4; cmd_freq_idx = 6'd5; cmd_div = 16'd0;
    @(negedge Fg_clk);
    chk("d0_accept", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    start = 1'b1;
    @(negedge Fg_clk);
    chk("d0_init1", osc_init1, I5A);
    step();
    start = 1'b0;
    @(negedge Fg_clk);
    chk("d0_prime_ready", {31'd0, osc_ready}, 32'd1);
    chk("d0_prime_en", {31'd0, osc_enable}, 32'd0);
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge Fg_clk);
      chk($sformatf("d0_en_%0d", i), {31'd0, osc_enable}, 32'd1);
      step();
    end
    cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_freq_idx = 6'd9; cmd_div = 16'd0;
    @(negedge Fg_clk);
    chk("d0_sample_cnt10", sample_cnt, exp_cnt10);
    chk("d0_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    step();
    step();
    @(negedge Fg_clk);
    chk("d0_restart_ready", {31'd0, osc_ready}, 32'd1);
    chk("d0_restart_en", {31'd0, osc_enable}, 32'd0);
    chk("d0_restart_fc", {31'd0, osc_freqchng}, 32'd0);
    step();
    @(negedge Fg_clk);
    chk("d0_cnt_after_prime", sample_cnt, 32'd0);
    chk("d0_en_after_prime", {31'd0, osc_enable}, 32'd1);
    chk("d0_mode2", {29'd0, osc_mode}, 32'd2);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    @(negedge Fg_clk);
    chk("d0_stopped_run", {31'd0, running}, 32'd0);
    chk("d0_stopped_en", {31'd0, osc_enable}, 32'd0);
    step();

    // Reset during FETCH, then start without a command
    cmd_valid = 1'b1; cmd_mode = 3'd1; cmd_freq_idx = 6'd7; cmd_div = 16'd5;
    step();
    cmd_valid = 1'b0;
    Resetn = 1'b0;
    @(negedge Fg_clk);
    chk("rf_fetch_addr", {26'd0, tbl_addr}, 32'd7);
    step();
    @(negedge Fg_clk);
    chk("rf_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rf_osc_ready", {31'd0, osc_ready}, 32'd0);
    chk("rf_enable", {31'd0, osc_enable}, 32'd0);
    chk("rf_freqchng", {31'd0, osc_freqchng}, 32'd0);
    chk("rf_running", {31'd0, running}, 32'd0);
    chk("rf_mode", {29'd0, osc_mode}, 32'd0);
    chk("rf_init1", osc_init1, 32'd0);
    chk("rf_init2", osc_init2, 32'd0);
    chk("rf_tbl_addr", {26'd0, tbl_addr}, 32'd0);
    chk("rf_sample_cnt", sample_cnt, 32'd0);
    step();
    Resetn = 1'b1;
    start = 1'b1;
    @(negedge Fg_clk);
    chk("rf_idle_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Fg_clk);
      chk($sformatf("rf_start_ign_rdy_%0d", i), {31'd0, osc_ready}, 32'd0);
      chk($sformatf("rf_start_ign_run_%0d", i), {31'd0, running}, 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osc_sequencer.md
Name: osc_sequencer

Overview:
- Control front-end for the DDS sine oscillator datapath: accepts frequency/mode commands from the host and fetches the sin(B)/2cos(B) coefficient pair from an external coefficient ROM.
- Drives the oscillator's Ready, Enable, Mode, init1, init2 and FreqChng inputs.
- Sequences cold start (prime), sample-rate ticking, glitch-free frequency change (FreqChng) and full restart on mode change.
- Sits between the host register interface and the oscillator.

Parameters:
- DATA_W, 32, width of coefficient words and oscillator init values
- IDX_W, 6, width of frequency index (ROM address)
- DIV_W, 16, width of sample-tick divisor

Ports:
- Fg_clk  in  1  clock
- Resetn  in  1  reset; synchronous, active-low
- start  in  1  begin oscillation (level sampled each cycle)
- stop  in  1  halt oscillation
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_mode  in  3  oscillator mode 0..4
- cmd_freq_idx  in  IDX_W  coefficient ROM index
- cmd_div  in  DIV_W  osc_enable every cmd_div+1 cycles
- tbl_addr  out  IDX_W  ROM address; data valid 1 cycle later
- tbl_sin  in  DATA_W  sin(B), Q3.29 signed
- tbl_cos  in  DATA_W  2cos(B), Q3.29 signed
- osc_ready  out  1  one-cycle prime pulse to oscillator
- osc_enable  out  1  sample tick
- osc_freqchng  out  1  one-cycle frequency-change request
- osc_mode  out  3  registered mode
- osc_init1  out  DATA_W  registered sin(B)
- osc_init2  out  DATA_W  registered 2cos(B)
- running  out  1  high in RUN and in-run update states
- sample_cnt  out  32  tick counter (see Optional Feature)

Behaviour:
- Reset: state IDLE. All outputs 0, cfg_loaded=0, divider count=0.
  - A reset asserted mid-operation aborts any fetch; no partial pulses are emitted on the following cycle.
- States: IDLE, FETCH, LATCH, PRIME, RUN, CHANGE.
- cmd_ready: 1 only in IDLE or RUN, and only while stop=0.
  - stop and cmd_valid in the same cycle: stop wins and the command is not accepted.
- Command accept: capture mode/idx/div into shadow registers, drive tbl_addr=idx, go to FETCH.
  - FETCH: 1 cycle for ROM latency.
  - LATCH: osc_init1<=tbl_sin, osc_init2<=tbl_cos, osc_mode<=shadow mode, div<=shadow div, cfg_loaded<=1.
- After LATCH:
  - Entered from IDLE: return to IDLE.
  - Entered from RUN with the same mode as current: go to CHANGE.
  - Entered from RUN with a different mode: go to PRIME.
- CHANGE: osc_freqchng=1 for exactly 1 cycle, then RUN.
  - The oscillator applies the new coefficients at its next zero crossing; init regs stay stable until the next command.
- IDLE + start=1 + cfg_loaded=1: go to PRIME. start with cfg_loaded=0 is ignored.
- PRIME: osc_ready=1 for exactly 1 cycle, osc_enable=0, divider count cleared, then RUN.
- RUN, FETCH/LATCH/CHANGE entered from RUN (running=1): divider counts 0..div.
  - osc_enable=1 in the cycle count==div, then count wraps to 0.
  - div=0 gives osc_enable every cycle.
  - A div change takes effect at LATCH; the count is reset to 0 at that point.
- stop=1 in any running state: go to IDLE next cycle, with osc_enable, osc_freqchng and osc_ready forced 0.
  - An in-flight fetch is abandoned; init regs keep their last latched values.
  - cfg_loaded is cleared only if the LATCH did not complete.
- start while already running: ignored.
- osc_ready and osc_freqchng are never both high in the same cycle.
- osc_enable is never high in the same cycle as osc_ready.

Optional Feature:
- Macro: OSC_SEQ_TICKCNT_EN.
- Defined: sample_cnt increments by 1 (wrapping at 2^32) on every osc_enable and is cleared to 0 in PRIME and on reset.
- Undefined: sample_cnt is tied to 0 and no counter logic is generated.

Decomposition:
- Package osc_seq_pkg holds:
  - state enum typedef
  - mode constants MODE_MAX=4 and MODE_FINE=4 (the mode using the 9-bit zero-cross window)
  - default widths
- Sub-module osc_tick_div: loadable modulo counter (div input, clear, run) producing the osc_enable pulse.

Test Plan:
- Reset, then cmd(mode=0, idx=5, div=3), ROM[5]={0x0100_0000, 0x3FF0_0000} -> IDLE with osc_init1/2 equal to those words; start -> single osc_ready pulse, then osc_enable every 4th cycle.
- In RUN, cmd(mode=0, idx=9) -> exactly one osc_freqchng pulse 3 cycles after accept; osc_enable cadence uninterrupted except for the count reset at LATCH.
- In RUN, cmd(mode=4, idx=9) -> no osc_freqchng; osc_ready pulse; osc_mode=4; ticking resumes after PRIME.
- stop and cmd_valid asserted together while running -> cmd_ready=0, IDLE next cycle, osc_enable=0 thereafter.
- div=0 -> osc_enable high every RUN cycle; with OSC_SEQ_TICKCNT_EN, sample_cnt=10 after 10 RUN cycles, and 0 after a restart PRIME.
- Resetn deasserted (driven low) during FETCH -> all outputs 0 the next cycle; a subsequent start with no new command is ignored.
